// File: rtl/retry_req_responder_pkg.sv
// Shared types and default widths for the link-layer retry responder.
package retry_pkg;
  localparam int RETRY_PTR_W = 8;
  localparam int RETRY_NUM_W = 5;

  typedef enum logic [1:0] {IDLE, SEND_ACK, REPLAY} rsp_state_e;
endpackage

// File: rtl/retry_req_responder_if.sv
// Request/Ack/replay signals between the unpacker/packer side and the retry responder.
interface retry_req_responder_if #(
  parameter int PTR_W = 8,
  parameter int NUM_W = 5
);
  logic             i_retry_req_vld;
  logic [NUM_W-1:0] i_retry_req_num;
  logic [PTR_W-1:0] i_retry_req_eseq;
  logic [PTR_W-1:0] i_llrb_oldest_ptr;
  logic [PTR_W-1:0] i_llrb_wr_ptr;
  logic             o_ack_vld;
  logic             i_ack_rdy;
  logic [NUM_W-1:0] o_ack_num;
  logic             o_ack_empty;
  logic [PTR_W-1:0] o_ack_wrptr;
  logic             o_replay_vld;
  logic             i_replay_rdy;
  logic [PTR_W-1:0] o_replay_ptr;
  logic             o_replay_last;
  logic             o_busy;
  logic             o_eseq_err;

  modport slave (
    input  i_retry_req_vld, i_retry_req_num, i_retry_req_eseq,
           i_llrb_oldest_ptr, i_llrb_wr_ptr, i_ack_rdy, i_replay_rdy,
    output o_ack_vld, o_ack_num, o_ack_empty, o_ack_wrptr,
           o_replay_vld, o_replay_ptr, o_replay_last, o_busy, o_eseq_err
  );

  modport master (
    output i_retry_req_vld, i_retry_req_num, i_retry_req_eseq,
           i_llrb_oldest_ptr, i_llrb_wr_ptr, i_ack_rdy, i_replay_rdy,
    input  o_ack_vld, o_ack_num, o_ack_empty, o_ack_wrptr,
           o_replay_vld, o_replay_ptr, o_replay_last, o_busy, o_eseq_err
  );
endinterface

// File: rtl/retry_req_responder_window_check.sv
// Combinational check of a requested Eseq against the live LLRB window [oldest, wr].
module retry_window_check #(
  parameter int PTR_W = 8
) (
  input  logic [PTR_W-1:0] oldest,
  input  logic [PTR_W-1:0] wr,
  input  logic [PTR_W-1:0] eseq,
  output logic             in_window,
  output logic [PTR_W-1:0] cnt
);
  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] off;

  // Offsets relative to oldest make the wrapped window a plain unsigned compare.
  always_comb begin
    occ       = wr - oldest;
    off       = eseq - oldest;
    in_window = (off <= occ);
    cnt       = in_window ? (wr - eseq) : '0;
  end
endmodule

// File: rtl/retry_req_responder.sv
// Transmit-side RETRY.Req responder: issues RETRY.Ack, then streams LLRB replay addresses.
module retry_req_responder
  import retry_pkg::*;
#(
  parameter int PTR_W = RETRY_PTR_W,
  parameter int NUM_W = RETRY_NUM_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  retry_req_responder_if.slave  bus
);
  rsp_state_e       state_q, state_d;
  logic [NUM_W-1:0] num_q;
  logic [PTR_W-1:0] eseq_q;
  logic [PTR_W-1:0] wr_snap_q;
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_nxt;
  logic             empty_q;
  logic             err_q;
  logic             req;
  logic             ack_acc;
  logic             rep_acc;
  logic             last_beat;
  logic             in_window;
  logic [PTR_W-1:0] cnt;

  retry_window_check #(.PTR_W(PTR_W)) u_window (
    .oldest    (bus.i_llrb_oldest_ptr),
    .wr        (bus.i_llrb_wr_ptr),
    .eseq      (bus.i_retry_req_eseq),
    .in_window (in_window),
    .cnt       (cnt)
  );

  // A new request always wins over a same-cycle accept.
  assign req       = bus.i_retry_req_vld;
  assign ack_acc   = (state_q == SEND_ACK) && bus.i_ack_rdy && !req;
  assign rep_acc   = (state_q == REPLAY) && bus.i_replay_rdy && !req;
  assign ptr_nxt   = ptr_q + PTR_W'(1);
  assign last_beat = (ptr_nxt == wr_snap_q);

  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d = SEND_ACK;
    end else begin
      unique case (state_q)
        IDLE:     state_d = IDLE;
        SEND_ACK: if (bus.i_ack_rdy) state_d = empty_q ? IDLE : REPLAY;
        REPLAY:   if (bus.i_replay_rdy && last_beat) state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      eseq_q    <= '0;
      wr_snap_q <= '0;
      empty_q   <= 1'b0;
      err_q     <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= req && !in_window;
      if (req) begin
        num_q     <= bus.i_retry_req_num;
        eseq_q    <= bus.i_retry_req_eseq;
        wr_snap_q <= bus.i_llrb_wr_ptr;
        empty_q   <= (cnt == '0);
      end
      if (ack_acc) begin
        ptr_q <= eseq_q;
      end else if (rep_acc) begin
        ptr_q <= ptr_nxt;
      end
    end
  end

  assign bus.o_ack_vld     = (state_q == SEND_ACK);
  assign bus.o_ack_num     = num_q;
  assign bus.o_ack_empty   = empty_q;
  assign bus.o_ack_wrptr   = wr_snap_q;
  assign bus.o_replay_vld  = (state_q == REPLAY);
  assign bus.o_replay_ptr  = ptr_q;
  assign bus.o_replay_last = (state_q == REPLAY) && last_beat;
  assign bus.o_busy        = (state_q != IDLE);
  assign bus.o_eseq_err    = err_q;
endmodule

// File: tb/tb_retry_req_responder.sv
// Bench for retry_req_responder: queue-based reference model plus directed literal scenarios.
module tb_retry_req_responder;
  localparam int PW = 8;
  localparam int NW = 5;
  localparam int M  = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  retry_req_responder_if #(.PTR_W(PW), .NUM_W(NW)) bus ();

  retry_req_responder #(.PTR_W(PW), .NUM_W(NW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pending Ack flag plus the list of slots still to replay.
  logic          m_ack = 1'b0;
  logic          m_err = 1'b0;
  logic          m_empty = 1'b0;
  int            m_num = 0;
  int            m_wr = 0;
  int            m_q[$];
  int            occ, off, n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack = 1'b0; m_err = 1'b0; m_empty = 1'b0; m_num = 0; m_wr = 0;
      m_q.delete();
    end else if (bus.i_retry_req_vld) begin
      occ = (int'(bus.i_llrb_wr_ptr) - int'(bus.i_llrb_oldest_ptr)) & M;
      off = (int'(bus.i_retry_req_eseq) - int'(bus.i_llrb_oldest_ptr)) & M;
      m_q.delete();
      if (off <= occ) begin
        n = (int'(bus.i_llrb_wr_ptr) - int'(bus.i_retry_req_eseq)) & M;
        for (int k = 0; k < n; k++) m_q.push_back((int'(bus.i_retry_req_eseq) + k) & M);
      end
      m_err   = !(off <= occ);
      m_ack   = 1'b1;
      m_num   = int'(bus.i_retry_req_num);
      m_wr    = int'(bus.i_llrb_wr_ptr);
      m_empty = (m_q.size() == 0);
    end else begin
      m_err = 1'b0;
      if (m_ack) begin
        if (bus.i_ack_rdy) m_ack = 1'b0;
      end else if (m_q.size() > 0 && bus.i_replay_rdy) begin
        void'(m_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    bit rv;
    rv = !m_ack && (m_q.size() > 0);
    chk("ack_vld", int'(bus.o_ack_vld), int'(m_ack));
    if (m_ack) begin
      chk("ack_num", int'(bus.o_ack_num), m_num);
      chk("ack_empty", int'(bus.o_ack_empty), int'(m_empty));
      chk("ack_wrptr", int'(bus.o_ack_wrptr), m_wr);
    end
    chk("replay_vld", int'(bus.o_replay_vld), int'(rv));
    if (rv) chk("replay_ptr", int'(bus.o_replay_ptr), m_q[0]);
    chk("replay_last", int'(bus.o_replay_last), int'(rv && m_q.size() == 1));
    chk("busy", int'(bus.o_busy), int'(m_ack || m_q.size() > 0));
    chk("eseq_err", int'(bus.o_eseq_err), int'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_req(input int num, input int eseq, input int old, input int wr);
    bus.i_llrb_oldest_ptr = PW'(old);
    bus.i_llrb_wr_ptr     = PW'(wr);
    bus.i_retry_req_num   = NW'(num);
    bus.i_retry_req_eseq  = PW'(eseq);
    bus.i_retry_req_vld   = 1'b1;
    tick();
    bus.i_retry_req_vld   = 1'b0;
  endtask

  task automatic accept_ack(input int hold, input int num, input int empty, input int wr);
    for (int i = 0; i <= hold; i++) begin
      chk("lit_ack_vld", int'(bus.o_ack_vld), 1);
      chk("lit_ack_num", int'(bus.o_ack_num), num);
      chk("lit_ack_empty", int'(bus.o_ack_empty), empty);
      chk("lit_ack_wrptr", int'(bus.o_ack_wrptr), wr);
      if (i < hold) tick();
    end
    bus.i_ack_rdy = 1'b1;
    tick();
    bus.i_ack_rdy = 1'b0;
  endtask

  task automatic run_replay(input int start, input int count, input bit toggle);
    int got = 0;
    int budget = 4 * count + 20;
    while (got < count && budget > 0) begin
      bus.i_replay_rdy = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.o_replay_vld && bus.i_replay_rdy) begin
        chk("lit_replay_ptr", int'(bus.o_replay_ptr), (start + got) & M);
        chk("lit_replay_last", int'(bus.o_replay_last), int'(got == count - 1));
        got++;
      end
      tick();
      budget--;
    end
    bus.i_replay_rdy = 1'b0;
    chk("lit_replay_beats", got, count);
    chk("lit_idle_after", int'(bus.o_busy), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, int'({bus.o_ack_vld, bus.o_ack_num, bus.o_ack_empty, bus.o_ack_wrptr,
                  bus.o_replay_vld, bus.o_replay_ptr, bus.o_replay_last,
                  bus.o_busy, bus.o_eseq_err}), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int budget;
    bus.i_retry_req_vld = 1'b0; bus.i_retry_req_num = '0; bus.i_retry_req_eseq = '0;
    bus.i_llrb_oldest_ptr = '0; bus.i_llrb_wr_ptr = '0;
    bus.i_ack_rdy = 1'b0; bus.i_replay_rdy = 1'b0;
    tick(); tick();
    chk_all_zero("lit_reset_outputs");
    rst = 1'b0;
    tick();

    // Basic replay 15..19.
    send_req(3, 15, 10, 20);
    accept_ack(0, 3, 0, 20);
    run_replay(15, 5, 1'b0);

    // Eseq == wr: empty Ack, no replay.
    send_req(1, 20, 10, 20);
    accept_ack(0, 1, 1, 20);
    chk("lit_empty_no_replay", int'(bus.o_replay_vld), 0);
    chk("lit_empty_idle", int'(bus.o_busy), 0);

    // Eseq beyond wr: error pulse, empty Ack.
    send_req(2, 25, 10, 20);
    chk("lit_err_pulse", int'(bus.o_eseq_err), 1);
    accept_ack(0, 2, 1, 20);
    chk("lit_err_clear", int'(bus.o_eseq_err), 0);

    // Wrapped window.
    send_req(5, 254, 250, 4);
    accept_ack(0, 5, 0, 4);
    run_replay(254, 6, 1'b0);

    // Back-pressure on Ack and replay.
    send_req(6, 15, 10, 20);
    accept_ack(5, 6, 0, 20);
    run_replay(15, 5, 1'b1);

    // Supersede during replay at ptr 17.
    send_req(3, 15, 10, 20);
    accept_ack(0, 3, 0, 20);
    bus.i_replay_rdy = 1'b1;
    budget = 10;
    while (int'(bus.o_replay_ptr) != 17 && budget > 0) begin tick(); budget--; end
    chk("lit_reach_17", int'(bus.o_replay_ptr), 17);
    bus.i_llrb_oldest_ptr = PW'(10); bus.i_llrb_wr_ptr = PW'(20);
    bus.i_retry_req_num = NW'(4); bus.i_retry_req_eseq = PW'(12); bus.i_retry_req_vld = 1'b1;
    tick();
    bus.i_retry_req_vld = 1'b0; bus.i_replay_rdy = 1'b0;
    chk("lit_sup_replay_drop", int'(bus.o_replay_vld), 0);
    accept_ack(0, 4, 0, 20);
    run_replay(12, 8, 1'b0);

    // Full LLRB and zero-occupancy corners.
    send_req(7, 3, 3, 2);
    accept_ack(0, 7, 0, 2);
    run_replay(3, 255, 1'b0);
    send_req(0, 9, 9, 9);
    chk("lit_occ0_ok", int'(bus.o_eseq_err), 0);
    accept_ack(0, 0, 1, 9);
    send_req(0, 10, 9, 9);
    chk("lit_occ0_err", int'(bus.o_eseq_err), 1);
    accept_ack(0, 0, 1, 9);

    // Reset mid-replay.
    send_req(3, 15, 10, 20);
    accept_ack(0, 3, 0, 20);
    bus.i_replay_rdy = 1'b1;
    tick();
    bus.i_replay_rdy = 1'b0;
    rst = 1'b1;
    #1;
    chk_all_zero("lit_async_reset");
    tick();
    rst = 1'b0;
    tick();
    send_req(3, 15, 10, 20);
    accept_ack(0, 3, 0, 20);
    run_replay(15, 5, 1'b0);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 4000; c++) begin
      int old;
      old = int'($urandom_range(0, M));
      bus.i_llrb_oldest_ptr = PW'(old);
      bus.i_llrb_wr_ptr     = PW'(old + int'($urandom_range(0, 40)));
      bus.i_retry_req_eseq  = ($urandom_range(0, 7) == 0) ? PW'($urandom)
                                                          : PW'(old + int'($urandom_range(0, 45)));
      bus.i_retry_req_num   = NW'($urandom);
      bus.i_retry_req_vld   = ($urandom_range(0, 24) == 0);
      bus.i_ack_rdy         = ($urandom_range(0, 2) != 0);
      bus.i_replay_rdy      = ($urandom_range(0, 2) != 0);
      rst                   = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    bus.i_retry_req_vld = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
